// File: rtl/iob_split_pipe.sv
// Address-decoded IOb splitter with in-order read tracking (up to MAX_OUT reads to one slave); define IOB_SPLIT_ERR_EN for an error slave.
// Zero-latency request/response paths; m_ready follows the selected slave's s_ready, gated by the tracking stall.
module iob_split_pipe #(
  parameter int N_SLAVES = 2,
  parameter int P_SLAVES = 31,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUT  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_avalid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic                       m_ready,
  output logic                       m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic [N_SLAVES-1:0]        s_avalid,
  output logic [N_SLAVES*ADDR_W-1:0] s_addr,
  output logic [N_SLAVES*DATA_W-1:0] s_wdata,
  output logic [N_SLAVES*DATA_W/8-1:0] s_wstrb,
  input  logic [N_SLAVES-1:0]        s_ready,
  input  logic [N_SLAVES-1:0]        s_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  output logic                       err
);

`ifdef IOB_SPLIT_ERR_EN
  localparam int N_TGT = N_SLAVES + 1;
`else
  localparam int N_TGT = N_SLAVES;
`endif
  localparam int SEL_W  = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int TGT_SZ = 2 ** SEL_W;
  localparam int CNT_W  = $clog2(MAX_OUT + 1);

  logic [SEL_W-1:0]  sel, idx, tgt;
  logic [CNT_W-1:0]  cnt;
  logic              rd, fwd, last, stall, acc_rd;
  logic              t_rdy  [TGT_SZ];
  logic              t_rvld [TGT_SZ];
  logic [DATA_W-1:0] t_rdat [TGT_SZ];

  assign sel = m_addr[P_SLAVES -: SEL_W];
  assign rd  = (m_wstrb == '0);

  // Out-of-range selections go to the error slave, or fold onto the last slave.
  always_comb begin
    idx = sel;
    if (32'(sel) >= 32'(N_SLAVES)) begin
`ifdef IOB_SPLIT_ERR_EN
      idx = SEL_W'(N_SLAVES);
`else
      idx = SEL_W'(N_SLAVES - 1);
`endif
    end
  end

`ifdef IOB_SPLIT_ERR_EN
  logic err_rvalid;
  logic err_acc;

  assign err_acc = m_avalid & m_ready & (idx == SEL_W'(N_SLAVES));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_rvalid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err_rvalid <= err_acc & rd;
      if (err_acc) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < TGT_SZ; i++) begin
      t_rdy[i]  = 1'b0;
      t_rvld[i] = 1'b0;
      t_rdat[i] = '0;
    end
    for (int i = 0; i < N_SLAVES; i++) begin
      t_rdy[i]  = s_ready[i];
      t_rvld[i] = s_rvalid[i];
      t_rdat[i] = s_rdata[i*DATA_W +: DATA_W];
    end
`ifdef IOB_SPLIT_ERR_EN
    t_rdy[N_SLAVES]  = 1'b1;
    t_rvld[N_SLAVES] = err_rvalid;
`endif
  end

  assign fwd  = (cnt != '0) & t_rvld[tgt];
  assign last = (cnt == CNT_W'(1)) & fwd;

  // A read may switch slaves in the very cycle the final outstanding response drains.
  assign stall = rd & (((cnt == CNT_W'(MAX_OUT)) & ~fwd) |
                       ((cnt != '0) & (idx != tgt) & ~last));

  assign m_ready  = t_rdy[idx] & ~stall;
  assign m_rvalid = fwd;
  assign m_rdata  = fwd ? t_rdat[tgt] : '0;
  assign acc_rd   = m_avalid & m_ready & rd;

  always_comb begin
    s_avalid = '0;
    for (int i = 0; i < N_SLAVES; i++)
      s_avalid[i] = m_avalid & (idx == SEL_W'(i)) & ~stall;
  end

  assign s_addr  = {N_SLAVES{m_addr}};
  assign s_wdata = {N_SLAVES{m_wdata}};
  assign s_wstrb = {N_SLAVES{m_wstrb}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tgt <= '0;
    end else begin
      if (acc_rd & ~fwd)      cnt <= cnt + CNT_W'(1);
      else if (fwd & ~acc_rd) cnt <= cnt - CNT_W'(1);
      if (acc_rd) tgt <= idx;
    end
  end

endmodule
